// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory access controller, MEM stage load/store to a req/ack SRAM bus.
// Optional wait-state timeout with bus error is built when DM_TIMEOUT_EN is defined.
module dm_ctrl #(
   parameter int TO_WIDTH = 8,
   parameter int TO_LIMIT = 255
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_bsel_i,
   input  logic        flush_i,
   output logic        stall_req_o,
   output logic [31:0] dm_o,
   output logic        dm_valid_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        bus_err_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
   state_t state;
   logic   abort;
`ifdef DM_TIMEOUT_EN
   logic [TO_WIDTH-1:0] to_cnt;
`else
   assign bus_err_o = 1'b0;
`endif
   // Gated by reset so the stall also drops asynchronously with the bus request.
   assign stall_req_o = cpu_rst_n & (((state == IDLE) & mem_req_i & ~flush_i) | (state == REQ));
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
      if (!cpu_rst_n) begin
         state       <= IDLE;
         abort       <= 1'b0;
         dm_o        <= '0;
         dm_valid_o  <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
`ifdef DM_TIMEOUT_EN
         bus_err_o   <= 1'b0;
         to_cnt      <= '0;
`endif
      end else begin
         dm_valid_o <= 1'b0;
`ifdef DM_TIMEOUT_EN
         bus_err_o  <= 1'b0;
`endif
         case (state)
            IDLE:
               if (mem_req_i && !flush_i) begin
                  state       <= REQ;
                  abort       <= 1'b0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= mem_we_i;
                  bus_addr_o  <= mem_addr_i & ~32'h3;
                  bus_wdata_o <= mem_wdata_i;
                  bus_be_o    <= mem_bsel_i;
`ifdef DM_TIMEOUT_EN
                  to_cnt      <= '0;
`endif
               end
            REQ: begin
               if (flush_i)
                  abort <= 1'b1;
               // A flush landing on the ack cycle aborts the load just like an earlier one.
               if (bus_ack_i) begin
                  state     <= DONE;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  if (!bus_we_o && !abort && !flush_i) begin
                     dm_o       <= bus_rdata_i;
                     dm_valid_o <= 1'b1;
                  end
               end
`ifdef DM_TIMEOUT_EN
               else if (to_cnt == TO_WIDTH'(TO_LIMIT - 1)) begin
                  state     <= DONE;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  bus_err_o <= 1'b1;
                  dm_o      <= '0;
               end else
                  to_cnt <= to_cnt + 1'b1;
`endif
            end
            default:
               state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: table-driven per-cycle vectors for dm_ctrl plus a hand-written async reset sequence.
// The timeout vectors are included only when DM_TIMEOUT_EN is defined.
module tb_dm_ctrl;
   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        mem_req_i = 1'b0, mem_we_i = 1'b0, flush_i = 1'b0, bus_ack_i = 1'b0;
   logic [31:0] mem_addr_i = '0, mem_wdata_i = '0, bus_rdata_i = '0;
   logic [3:0]  mem_bsel_i = '0;
   logic        stall_req_o, dm_valid_o, bus_req_o, bus_we_o, bus_err_o;
   logic [31:0] dm_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   int checks = 0, failures = 0, vec_no = 0;

   dm_ctrl #(.TO_WIDTH(8), .TO_LIMIT(4)) dut (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_bsel_i(mem_bsel_i), .flush_i(flush_i),
      .stall_req_o(stall_req_o), .dm_o(dm_o), .dm_valid_o(dm_valid_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i),
      .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
   );

   always #10 cpu_clk_50M = ~cpu_clk_50M;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        req, we, flush, ack;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  bsel;
      logic        stall, breq, bwe, valid, err;
      logic [31:0] baddr, bwdata, dm;
      logic [3:0]  be;
   } vec_t;
   vec_t tbl[$];

   function automatic void v(input logic req, we, flush, ack, input logic [31:0] addr, wdata, rdata,
                             input logic [3:0] bsel, input logic stall, breq, bwe, valid, err,
                             input logic [31:0] baddr, bwdata, dm, input logic [3:0] be);
      tbl.push_back('{req, we, flush, ack, addr, wdata, rdata, bsel,
                      stall, breq, bwe, valid, err, baddr, bwdata, dm, be});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, vec_no, act, exp);
      end
   endtask

   // One vector per clock cycle: inputs driven just after the edge, outputs sampled mid-cycle.
   task automatic run_tbl();
      foreach (tbl[i]) begin
         @(posedge cpu_clk_50M);
         #1;
         mem_req_i = tbl[i].req; mem_we_i = tbl[i].we; flush_i = tbl[i].flush; bus_ack_i = tbl[i].ack;
         mem_addr_i = tbl[i].addr; mem_wdata_i = tbl[i].wdata; bus_rdata_i = tbl[i].rdata;
         mem_bsel_i = tbl[i].bsel;
         #2;
         chk("stall_req", 32'(stall_req_o), 32'(tbl[i].stall));
         chk("bus_req", 32'(bus_req_o), 32'(tbl[i].breq));
         chk("dm", dm_o, tbl[i].dm);
         chk("dm_valid", 32'(dm_valid_o), 32'(tbl[i].valid));
         chk("bus_err", 32'(bus_err_o), 32'(tbl[i].err));
         if (tbl[i].breq) begin
            chk("bus_we", 32'(bus_we_o), 32'(tbl[i].bwe));
            chk("bus_addr", bus_addr_o, tbl[i].baddr);
            chk("bus_wdata", bus_wdata_o, tbl[i].bwdata);
            chk("bus_be", 32'(bus_be_o), 32'(tbl[i].be));
         end
         vec_no++;
      end
      tbl.delete();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " stall_req"}, 32'(stall_req_o), 0);
      chk({tag, " bus_req"}, 32'(bus_req_o), 0);
      chk({tag, " bus_we"}, 32'(bus_we_o), 0);
      chk({tag, " dm"}, dm_o, 0);
      chk({tag, " dm_valid"}, 32'(dm_valid_o), 0);
      chk({tag, " bus_addr"}, bus_addr_o, 0);
      chk({tag, " bus_wdata"}, bus_wdata_o, 0);
      chk({tag, " bus_be"}, 32'(bus_be_o), 0);
      chk({tag, " bus_err"}, 32'(bus_err_o), 0);
   endtask

   localparam logic [31:0] D1 = 32'hAABBCCDD, E1 = 32'h11111111, E2 = 32'h22222222, C1 = 32'hCAFEF00D;

   initial begin
      #5;
      chk_reset_values("por");
      repeat (2) @(posedge cpu_clk_50M);
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;

      // load, zero wait states
      v(1,0,0,0, 'h1006,0,0,          4'b0100, 1,0,0,0,0, 0,0,0,0);
      v(1,0,0,1, 'h1006,0,D1,         4'b0100, 1,1,0,0,0, 'h1004,0,0,4'b0100);
      v(1,0,0,0, 'h1006,0,0,          4'b0100, 0,0,0,1,0, 0,0,D1,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,D1,0);
      // store, 3 wait states; ack carries junk rdata that must not reach dm
      v(1,1,0,0, 'h20,'h12345678,0,   'hF,     1,0,0,0,0, 0,0,D1,0);
      for (int i = 0; i < 3; i++)
         v(1,1,0,0, 'h20,'h12345678,0, 'hF,    1,1,1,0,0, 'h20,'h12345678,D1,'hF);
      v(1,1,0,1, 'h20,'h12345678,'h99999999,'hF, 1,1,1,0,0, 'h20,'h12345678,D1,'hF);
      v(1,1,0,0, 'h20,'h12345678,0,   'hF,     0,0,0,0,0, 0,0,D1,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,D1,0);
      // flush while in REQ
      v(1,0,0,0, 'h40,0,0,            'hF,     1,0,0,0,0, 0,0,D1,0);
      v(1,0,0,0, 'h40,0,0,            'hF,     1,1,0,0,0, 'h40,0,D1,'hF);
      v(1,0,1,0, 'h40,0,0,            'hF,     1,1,0,0,0, 'h40,0,D1,'hF);
      v(0,0,0,1, 'h40,0,'hDEADBEEF,   'hF,     1,1,0,0,0, 'h40,0,D1,'hF);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,D1,0);
      // flush in IDLE blocks acceptance; stray ack outside REQ is ignored
      v(1,0,1,0, 'h80,0,0,            'hF,     0,0,0,0,0, 0,0,D1,0);
      v(0,0,0,1, 0,0,'h55555555,      0,       0,0,0,0,0, 0,0,D1,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,D1,0);
      // back-to-back loads with mem_req_i held high, waits 0 and 2
      v(1,0,0,0, 'h100,0,0,           'hF,     1,0,0,0,0, 0,0,D1,0);
      v(1,0,0,1, 'h100,0,E1,          'hF,     1,1,0,0,0, 'h100,0,D1,'hF);
      v(1,0,0,0, 'h104,0,0,           'hF,     0,0,0,1,0, 0,0,E1,0);
      v(1,0,0,0, 'h104,0,0,           'hF,     1,0,0,0,0, 0,0,E1,0);
      v(1,0,0,0, 'h104,0,0,           'hF,     1,1,0,0,0, 'h104,0,E1,'hF);
      v(1,0,0,0, 'h104,0,0,           'hF,     1,1,0,0,0, 'h104,0,E1,'hF);
      v(1,0,0,1, 'h104,0,E2,          'hF,     1,1,0,0,0, 'h104,0,E1,'hF);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,1,0, 0,0,E2,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,E2,0);
      run_tbl();

      // reset asserted mid-transaction, request still held
      @(posedge cpu_clk_50M);
      #1;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 'h200; mem_bsel_i = 'hF;
      @(posedge cpu_clk_50M);
      #3;
      chk("pre-reset bus_req", 32'(bus_req_o), 1);
      cpu_rst_n = 1'b0;
      #1;
      chk_reset_values("async reset");
      mem_req_i = 1'b0;
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;

      // normal load after reset release
      v(1,0,0,0, 'h300,0,0,           'h3,     1,0,0,0,0, 0,0,0,0);
      v(1,0,0,0, 'h300,0,0,           'h3,     1,1,0,0,0, 'h300,0,0,'h3);
      v(1,0,0,1, 'h300,0,C1,          'h3,     1,1,0,0,0, 'h300,0,0,'h3);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,1,0, 0,0,C1,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,C1,0);
`ifdef DM_TIMEOUT_EN
      // load with no ack: 4 REQ cycles, then DONE with bus error and dm cleared
      v(1,0,0,0, 'h400,0,0,           'hF,     1,0,0,0,0, 0,0,C1,0);
      for (int i = 0; i < 4; i++)
         v(1,0,0,0, 'h400,0,0,         'hF,     1,1,0,0,0, 'h400,0,C1,'hF);
      v(1,0,0,0, 'h400,0,0,           'hF,     0,0,0,0,1, 0,0,0,0);
      v(0,0,0,0, 0,0,0,               0,       0,0,0,0,0, 0,0,0,0);
`endif
      run_tbl();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
